// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  // SPI mode numbers, encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width = 0;
    while (width < 32 && (64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: tick every CLK_DIV cycles while run is high.
module spi_clk_div import spi_pkg::*; #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;

  // State changes only happen on tick, so wrapping on tick restarts the count on every state entry.
  always_ff @(posedge clk) begin
    if (reset || !run || tick) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  assign tick = run && (div_cnt == DIV_W'(CLK_DIV - 1));

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: all four modes, per-transfer chip select,
// valid/ready command handshake and a one-cycle rx_valid result pulse.
module spi_master_param import spi_pkg::*; #(
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned CLK_DIV  = 4,
  parameter  int unsigned NUM_CS   = 1,
  localparam int unsigned CS_SEL_W = (NUM_CS > 1) ? clog2(NUM_CS) : 1,
  localparam int unsigned CNT_W    = clog2(DATA_W + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic [CS_SEL_W-1:0] cs_sel,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic [CNT_W-1:0]    bit_cnt,
  output logic [NUM_CS-1:0]   spi_cs_n,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  localparam int unsigned EDGE_W    = clog2(2 * DATA_W + 1);
  localparam int unsigned LAST_EDGE = 2 * DATA_W - 1;

  spi_state_e        state, next_state;
  logic              tick;
  logic              accept, lead_edge, last_edge, shift_tick;
  logic              do_sample, do_shift, done;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [EDGE_W-1:0] edge_cnt;
  logic              cpol_q, cpha_q;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
    logic [NUM_CS-1:0] cs_n;
    cs_n = '1;
    for (int unsigned i = 0; i < NUM_CS; i++)
      if (sel == CS_SEL_W'(i)) cs_n[i] = 1'b0;
    return cs_n;
  endfunction

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .reset(reset),
    .run  (busy),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)            next_state = SETUP;
      SETUP:   if (tick)              next_state = SHIFT;
      SHIFT:   if (tick && last_edge) next_state = HOLD;
      HOLD:    if (tick)              next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  // edge_cnt holds the number of edges already produced, so edge_cnt even means the next edge is odd (leading).
  always_comb begin
    accept     = tx_valid && tx_ready;
    lead_edge  = !edge_cnt[0];
    last_edge  = (edge_cnt == EDGE_W'(LAST_EDGE));
    shift_tick = (state == SHIFT) && tick;
    do_sample  = shift_tick && (lead_edge != cpha_q);
    do_shift   = shift_tick && (cpha_q ? lead_edge : (!lead_edge && !last_edge));
    done       = (state == HOLD) && tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      bit_cnt  <= '0;
      spi_cs_n <= '1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
    end else begin
      tx_ready <= (next_state == IDLE);
      busy     <= (next_state != IDLE);
      rx_valid <= done;
      case (state)
        IDLE: begin
          spi_sclk <= cpol;
          if (accept) begin
            tx_sr    <= tx_data;
            rx_sr    <= '0;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            spi_cs_n <= cs_decode(cs_sel);
            spi_mosi <= cpha ? 1'b0 : tx_data[DATA_W-1];
            bit_cnt  <= '0;
            edge_cnt <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            spi_sclk <= !spi_sclk;
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        HOLD: begin
          spi_sclk <= cpol_q;
          if (tick) begin
            spi_cs_n <= '1;
            rx_data  <= rx_sr;
          end
        end
        default: ;
      endcase
      if (do_sample) begin
        rx_sr   <= {rx_sr[DATA_W-2:0], spi_miso};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // cpha=1 presents the current MSB on its edge; cpha=0 already shows it and advances to the next bit.
      if (do_shift) begin
        spi_mosi <= cpha_q ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
        tx_sr    <= tx_sr << 1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: a 16-bit/5-CS instance and an 8-bit/4-CS fast instance.
module tb_spi_master_param;
  import spi_pkg::*;

  typedef struct {
    logic [31:0] rx;
    int unsigned acc;
    int unsigned lat;
    logic [7:0]  cs_acc;
    int unsigned lo;
    int unsigned rises;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instance A: DATA_W=16, CLK_DIV=4, NUM_CS=5 so cs_sel=5 names a missing select
  logic [15:0] a_tx_data = '0;
  logic [2:0]  a_cs_sel = '0;
  logic        a_cpol = 1'b0, a_cpha = 1'b0, a_tx_valid = 1'b0;
  logic        a_tx_ready, a_rx_valid, a_busy, a_sclk, a_mosi, a_miso;
  logic [15:0] a_rx_data;
  logic [4:0]  a_bit_cnt;
  logic [4:0]  a_cs_n;
  logic        a_loop = 1'b1;
  logic        a_slave_miso;

  assign a_miso = a_loop ? a_mosi : a_slave_miso;

  spi_master_param #(.DATA_W(16), .CLK_DIV(4), .NUM_CS(5)) u_dut_a (
    .clk(clk), .reset(reset), .tx_data(a_tx_data), .cs_sel(a_cs_sel),
    .cpol(a_cpol), .cpha(a_cpha), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy), .bit_cnt(a_bit_cnt),
    .spi_cs_n(a_cs_n), .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_miso(a_miso)
  );

  // Instance B: DATA_W=8, CLK_DIV=1, NUM_CS=4, loopback
  logic [7:0] b_tx_data = '0;
  logic [1:0] b_cs_sel = '0;
  logic       b_cpol = 1'b0, b_cpha = 1'b0, b_tx_valid = 1'b0;
  logic       b_tx_ready, b_rx_valid, b_busy, b_sclk, b_mosi;
  logic [7:0] b_rx_data;
  logic [3:0] b_bit_cnt;
  logic [3:0] b_cs_n;

  spi_master_param #(.DATA_W(8), .CLK_DIV(1), .NUM_CS(4)) u_dut_b (
    .clk(clk), .reset(reset), .tx_data(b_tx_data), .cs_sel(b_cs_sel),
    .cpol(b_cpol), .cpha(b_cpha), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy), .bit_cnt(b_bit_cnt),
    .spi_cs_n(b_cs_n), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_mosi)
  );

  // Mode-3 slave on cs_n[0]: drives MISO on falling (leading) edges, samples MOSI on rising ones
  logic [15:0] slave_word = '0, s_tx = '0, s_rx = '0;
  logic        s_cs_q = 1'b1, s_sclk_q = 1'b1;
  always @(negedge clk) begin
    if (!a_cs_n[0] && s_cs_q) begin
      s_tx = slave_word;
      s_rx = '0;
    end else if (!a_cs_n[0] && a_sclk != s_sclk_q) begin
      if (!a_sclk) begin
        a_slave_miso = s_tx[15];
        s_tx = {s_tx[14:0], 1'b0};
      end else begin
        s_rx = {s_rx[14:0], a_mosi};
      end
    end
    s_cs_q   = a_cs_n[0];
    s_sclk_q = a_sclk;
  end

  // Monitors: latency is counted to the clock edge that first samples rx_valid high
  exp_t        a_exp_q[$], b_exp_q[$];
  int unsigned a_rxv_log[$];
  logic [7:0]  a_cs_acc = 8'hFF, b_cs_acc = 8'hFF;
  int unsigned a_lo = 0, a_rises = 0, b_lo = 0, b_rises = 0;
  logic        a_sclk_q = 1'b0, a_busy_q = 1'b0, b_sclk_q = 1'b0, b_busy_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      a_cs_acc = 8'hFF; a_lo = 0; a_rises = 0;
    end else begin
      if (a_busy) begin
        if (a_cs_n != 5'h1F) a_lo++;
        a_cs_acc &= {3'b111, a_cs_n};
        if (a_busy_q && a_sclk && !a_sclk_q) a_rises++;
      end
      if (a_rx_valid) begin
        a_rxv_log.push_back(cyc);
        chk("a_rxv_expected", 32'(a_exp_q.size() != 0), 32'd1);
        if (a_exp_q.size() != 0) begin
          e = a_exp_q.pop_front();
          chk("a_rx_data", 32'(a_rx_data), e.rx);
          chk("a_latency", cyc + 1 - e.acc, e.lat);
          chk("a_cs_n_mask", 32'(a_cs_acc), 32'(e.cs_acc));
          chk("a_cs_low_cycles", a_lo, e.lo);
          chk("a_sclk_rises", a_rises, e.rises);
          chk("a_cs_n_at_rxv", 32'(a_cs_n), 32'h1F);
        end
        a_cs_acc = 8'hFF; a_lo = 0; a_rises = 0;
      end
    end
    a_sclk_q = a_sclk;
    a_busy_q = a_busy;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      b_cs_acc = 8'hFF; b_lo = 0; b_rises = 0;
    end else begin
      if (b_busy) begin
        if (b_cs_n != 4'hF) b_lo++;
        b_cs_acc &= {4'hF, b_cs_n};
        if (b_busy_q && b_sclk && !b_sclk_q) b_rises++;
      end
      if (b_rx_valid) begin
        chk("b_rxv_expected", 32'(b_exp_q.size() != 0), 32'd1);
        if (b_exp_q.size() != 0) begin
          e = b_exp_q.pop_front();
          chk("b_rx_data", 32'(b_rx_data), e.rx);
          chk("b_latency", cyc + 1 - e.acc, e.lat);
          chk("b_cs_n_mask", 32'(b_cs_acc), 32'(e.cs_acc));
          chk("b_cs_low_cycles", b_lo, e.lo);
          chk("b_sclk_rises", b_rises, e.rises);
        end
        b_cs_acc = 8'hFF; b_lo = 0; b_rises = 0;
      end
    end
    b_sclk_q = b_sclk;
    b_busy_q = b_busy;
  end

  task automatic a_send(input logic [15:0] d, input logic [2:0] sel, input logic [1:0] mode,
                        input logic [15:0] exp_rx, input logic [7:0] exp_cs, input bit hold,
                        output int unsigned acc);
    exp_t e;
    bit   ok = 1'b0;
    a_tx_data = d; a_cs_sel = sel; {a_cpol, a_cpha} = mode; a_tx_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_tx_ready) begin ok = 1'b1; break; end
    end
    chk("a_accept", 32'(ok), 32'd1);
    if (ok) begin
      acc = cyc + 1;
      e.rx = 32'(exp_rx); e.acc = acc; e.lat = 137; e.cs_acc = exp_cs;
      e.lo = (exp_cs == 8'hFF) ? 0 : 136; e.rises = 16;
      a_exp_q.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) a_tx_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d, input logic [1:0] sel, input logic [1:0] mode,
                        input logic [7:0] exp_rx, input logic [7:0] exp_cs);
    exp_t e;
    bit   ok = 1'b0;
    b_tx_data = d; b_cs_sel = sel; {b_cpol, b_cpha} = mode; b_tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (b_tx_ready) begin ok = 1'b1; break; end
    end
    chk("b_accept", 32'(ok), 32'd1);
    if (ok) begin
      e.rx = 32'(exp_rx); e.acc = cyc + 1; e.lat = 19; e.cs_acc = exp_cs;
      e.lo = 18; e.rises = 8;
      b_exp_q.push_back(e);
    end
    @(posedge clk); #1;
    b_tx_valid = 1'b0;
  endtask

  task automatic a_wait_done();
    for (int i = 0; i < 400 && a_exp_q.size() != 0; i++) begin @(posedge clk); #2; end
    chk("a_drain", 32'(a_exp_q.size()), 32'd0);
  endtask

  task automatic b_wait_done();
    for (int i = 0; i < 400 && b_exp_q.size() != 0; i++) begin @(posedge clk); #2; end
    chk("b_drain", 32'(b_exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc1, acc2, n0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_ready", 32'(a_tx_ready), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_rx_valid", 32'(a_rx_valid), 32'd0);
    chk("rst_rx_data", 32'(a_rx_data), 32'd0);
    chk("rst_bit_cnt", 32'(a_bit_cnt), 32'd0);
    chk("rst_cs_n", 32'(a_cs_n), 32'h1F);
    chk("rst_sclk", 32'(a_sclk), 32'd0);
    chk("rst_mosi", 32'(a_mosi), 32'd0);
    chk("b_rst_cs_n", 32'(b_cs_n), 32'hF);
    chk("b_rst_bit_cnt", 32'(b_bit_cnt), 32'd0);
    reset = 1'b0;

    // Mode 0 loopback
    a_send(16'hA569, 3'd0, MODE0, 16'hA569, 8'hFE, 1'b0, acc1);
    a_wait_done();

    // Mode 3 against the slave model
    a_loop = 1'b0; slave_word = 16'h2563; a_cpol = 1'b1; a_cpha = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("m3_sclk_idle_before", 32'(a_sclk), 32'd1);
    a_send(16'h9B63, 3'd0, MODE3, 16'h2563, 8'hFE, 1'b0, acc1);
    a_wait_done();
    chk("m3_slave_rx", 32'(s_rx), 32'h9B63);
    chk("m3_sclk_idle_after", 32'(a_sclk), 32'd1);
    a_loop = 1'b1;

    // Back-to-back with tx_valid held high
    n0 = a_rxv_log.size();
    a_send(16'h6A61, 3'd0, MODE0, 16'h6A61, 8'hFE, 1'b1, acc1);
    a_send(16'hA265, 3'd0, MODE0, 16'hA265, 8'hFE, 1'b0, acc2);
    a_wait_done();
    chk("b2b_accept_in_rxv_cycle", acc2, (a_rxv_log.size() > n0) ? a_rxv_log[n0] + 1 : 0);

    // Reset mid-transfer at bit_cnt=7
    a_send(16'h7564, 3'd0, MODE0, 16'h7564, 8'hFE, 1'b0, acc1);
    for (int i = 0; i < 200 && a_bit_cnt != 5'd7; i++) begin @(posedge clk); #1; end
    chk("rst_mid_bit7", 32'(a_bit_cnt), 32'd7);
    reset = 1'b1;
    a_exp_q.delete();
    n0 = a_rxv_log.size();
    @(posedge clk); #1;
    chk("rst_mid_cs_n", 32'(a_cs_n), 32'h1F);
    chk("rst_mid_busy", 32'(a_busy), 32'd0);
    chk("rst_mid_bit_cnt", 32'(a_bit_cnt), 32'd0);
    chk("rst_mid_rx_valid", 32'(a_rx_valid), 32'd0);
    chk("rst_mid_tx_ready", 32'(a_tx_ready), 32'd1);
    reset = 1'b0;
    repeat (160) @(posedge clk);
    #1;
    chk("rst_mid_no_rxv", 32'(a_rxv_log.size()), 32'(n0));
    a_send(16'h7564, 3'd0, MODE0, 16'h7564, 8'hFE, 1'b0, acc1);
    a_wait_done();

    // Chip-select decode: existing and missing selects
    a_send(16'h3C5A, 3'd3, MODE0, 16'h3C5A, 8'hF7, 1'b0, acc1);
    a_wait_done();
    a_send(16'h5AA5, 3'd5, MODE2, 16'h5AA5, 8'hFF, 1'b0, acc1);
    a_wait_done();

    // Fast 8-bit instance
    b_send(8'hC3, 2'd2, MODE1, 8'hC3, 8'hFB);
    b_wait_done();
    b_send(8'h5A, 2'd0, MODE2, 8'h5A, 8'hFE);
    b_wait_done();

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
